// File: rtl/cpu_out_display.sv
// Aeolus CPU output stage: serial double-dabble converter feeding a 4-digit
// multiplexed active-low seven-segment display. Optional macro: LEADING_ZERO_BLANK_EN.
module cpu_out_display #(
    parameter int unsigned SCAN_DIV = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] valueIn,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an,
    output logic       busy
);

    localparam int unsigned SCAN_W = $clog2(SCAN_DIV);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZ_BLANK = 1'b1;
`else
    localparam bit LZ_BLANK = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        LATCH
    } state_e;

    state_e            state_q, state_d;
    logic [7:0]        last_value_q, last_value_d;
    logic [7:0]        shift_reg_q, shift_reg_d;
    logic [11:0]       bcd_work_q, bcd_work_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [11:0]       disp_bcd_q, disp_bcd_d;
    logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [1:0]        digit_sel_q, digit_sel_d;
    logic              busy_q, busy_d;

    logic [11:0]       bcd_adj;
    logic [3:0]        digit;
    logic              blank;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    always_comb begin
        state_d      = state_q;
        last_value_d = last_value_q;
        shift_reg_d  = shift_reg_q;
        bcd_work_d   = bcd_work_q;
        bit_cnt_d    = bit_cnt_q;
        disp_bcd_d   = disp_bcd_q;
        bcd_adj      = {add3(bcd_work_q[11:8]), add3(bcd_work_q[7:4]), add3(bcd_work_q[3:0])};

        case (state_q)
            IDLE: begin
                if (valueIn != last_value_q) begin
                    last_value_d = valueIn;
                    shift_reg_d  = valueIn;
                    bcd_work_d   = '0;
                    bit_cnt_d    = '0;
                    state_d      = CONVERT;
                end
            end
            CONVERT: begin
                {bcd_work_d, shift_reg_d} = {bcd_adj, shift_reg_q} << 1;
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    state_d = LATCH;
                end
            end
            LATCH: begin
                disp_bcd_d = bcd_work_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);

        scan_cnt_d  = scan_cnt_q + 1'b1;
        digit_sel_d = digit_sel_q;
        if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_d  = '0;
            digit_sel_d = digit_sel_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_value_q <= '0;
            shift_reg_q  <= '0;
            bcd_work_q   <= '0;
            bit_cnt_q    <= '0;
            disp_bcd_q   <= '0;
            scan_cnt_q   <= '0;
            digit_sel_q  <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_value_q <= last_value_d;
            shift_reg_q  <= shift_reg_d;
            bcd_work_q   <= bcd_work_d;
            bit_cnt_q    <= bit_cnt_d;
            disp_bcd_q   <= disp_bcd_d;
            scan_cnt_q   <= scan_cnt_d;
            digit_sel_q  <= digit_sel_d;
            busy_q       <= busy_d;
        end
    end

    // Leading-zero blanking only ever applies to tens/hundreds; digit 3 is always dark.
    always_comb begin
        digit = 4'd0;
        blank = 1'b0;
        case (digit_sel_q)
            2'd0: digit = disp_bcd_q[3:0];
            2'd1: begin
                digit = disp_bcd_q[7:4];
                blank = LZ_BLANK && (disp_bcd_q[11:4] == 8'd0);
            end
            2'd2: begin
                digit = disp_bcd_q[11:8];
                blank = LZ_BLANK && (disp_bcd_q[11:8] == 4'd0);
            end
            default: blank = 1'b1;
        endcase
    end

    assign seg  = blank ? 7'h7F : decode(digit);
    assign an   = ~(4'b0001 << digit_sel_q);
    assign dp   = 1'b1;
    assign busy = busy_q;

endmodule

// File: tb/tb_cpu_out_display.sv
// Randomized bench for cpu_out_display: two instances (SCAN_DIV 4 and 2) checked
// each cycle against a timer-based conversion model and arithmetic digit model.
module tb_cpu_out_display;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] valueIn = 8'd0;
    logic [6:0] seg_a, seg_b;
    logic       dp_a, dp_b, busy_a, busy_b;
    logic [3:0] an_a, an_b;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    int unsigned m_last, m_pend, m_disp, m_cnt, m_k;

    cpu_out_display #(.SCAN_DIV(4)) dut_a (
        .clk(clk), .reset(reset), .valueIn(valueIn),
        .seg(seg_a), .dp(dp_a), .an(an_a), .busy(busy_a)
    );

    cpu_out_display #(.SCAN_DIV(2)) dut_b (
        .clk(clk), .reset(reset), .valueIn(valueIn),
        .seg(seg_b), .dp(dp_b), .an(an_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned exp_seg(input int unsigned v, input int unsigned d);
        int unsigned h, t, o, dig;
        bit blank;
        h = v / 100;
        t = (v / 10) % 10;
        o = v % 10;
        blank = 1'b0;
        dig = 0;
        case (d)
            0: dig = o;
            1: begin
                dig = t;
`ifdef LEADING_ZERO_BLANK_EN
                blank = (h == 0) && (t == 0);
`endif
            end
            2: begin
                dig = h;
`ifdef LEADING_ZERO_BLANK_EN
                blank = (h == 0);
`endif
            end
            default: blank = 1'b1;
        endcase
        if (blank) return 32'h7F;
        case (dig)
            0: return 32'h40;
            1: return 32'h79;
            2: return 32'h24;
            3: return 32'h30;
            4: return 32'h19;
            5: return 32'h12;
            6: return 32'h02;
            7: return 32'h78;
            8: return 32'h00;
            default: return 32'h10;
        endcase
    endfunction

    // Inputs change 1 time unit after a sampling edge; outputs sampled 1 unit after it.
    task automatic step(input logic rst, input logic [7:0] v);
        int unsigned da, db;
        reset   = rst;
        valueIn = v;
        @(posedge clk);
        if (rst) begin
            m_last = 0; m_cnt = 0; m_disp = 0; m_k = 0;
        end else begin
            m_k++;
            if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) m_disp = m_pend;
            end else if (v != m_last) begin
                m_last = v;
                m_pend = v;
                m_cnt  = 9;
            end
        end
        #1;
        da = (m_k / 4) % 4;
        db = (m_k / 2) % 4;
        check_val("busy_a", busy_a, (m_cnt > 0) ? 1 : 0);
        check_val("busy_b", busy_b, (m_cnt > 0) ? 1 : 0);
        check_val("dp_a", dp_a, 1);
        check_val("dp_b", dp_b, 1);
        check_val("an_a", an_a, (~(32'd1 << da)) & 32'hF);
        check_val("an_b", an_b, (~(32'd1 << db)) & 32'hF);
        check_val("seg_a", seg_a, exp_seg(m_disp, da));
        check_val("seg_b", seg_b, exp_seg(m_disp, db));
        check_val("an_b_onehot", $countones(~an_b), 1);
    endtask

    initial begin
        int unsigned v, hold;
        m_last = 0; m_pend = 0; m_disp = 0; m_cnt = 0; m_k = 0;

        // Reset with zero input: no conversion must follow.
        step(1'b1, 8'd0);
        step(1'b1, 8'd0);
        repeat (12) step(1'b0, 8'd0);

        // Full scale, then small value for blanking.
        repeat (40) step(1'b0, 8'd255);
        repeat (40) step(1'b0, 8'd7);

        // Change during conversion is deferred until the next idle cycle.
        repeat (3) step(1'b0, 8'd100);
        repeat (30) step(1'b0, 8'd42);

        // Reset mid-conversion, then reconvert the same value.
        repeat (5) step(1'b0, 8'd200);
        step(1'b1, 8'd200);
        repeat (30) step(1'b0, 8'd200);

        // Transient value that reverts before the converter returns to idle.
        repeat (2) step(1'b0, 8'd9);
        repeat (30) step(1'b0, 8'd200);

        repeat (200) begin
            v    = $urandom_range(0, 255);
            hold = $urandom_range(1, 16);
            if ($urandom_range(0, 24) == 0) step(1'b1, v[7:0]);
            repeat (hold) step(1'b0, v[7:0]);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
